mod_updown_counter: RTL
=======================

# mod_updown_counter

Synchronous, parametrised modulo-N up/down counter built from toggle stages on a single clock edge. It is the successor to the 3-bit ripple T-flip-flop up counter. All bits update together on the rising edge of `clk`, so there is no ripple skew. It adds direction control, parallel load, synchronous clear, wrap or saturate mode, and terminal-count and wrap indications. It is used wherever the design needs a BCD digit, divider or event counter with a known modulus.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range ≥1.
- `MODULUS`, default 10: count range 0..MODULUS-1; legal range 2..2**WIDTH.
- `RESET_VAL`, default 0: value of `q` after reset; must be < MODULUS.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable.
- `up_dn` input 1: 1 = count up, 0 = count down.
- `sat` input 1: 0 = wrap at boundary, 1 = saturate (hold) at boundary.
- `clr` input 1: synchronous clear to 0.
- `load` input 1: synchronous parallel load.
- `load_val` input WIDTH: value to load.
- `q` output WIDTH: registered count.
- `tc` output 1: combinational terminal count. Equals `en` & (up_dn ? q==MODULUS-1 : q==0).
- `wrap` output 1: registered one-cycle pulse, high in the cycle after the counter wrapped.
- `held` output 1: registered level, high while the counter sits at a boundary after a saturating attempt.
- `load_err` output 1: registered one-cycle pulse, high in the cycle after a load with load_val ≥ MODULUS.

## Operation
- Reset: while `rst_n`=0, regardless of `clk`, q=RESET_VAL, wrap=0, held=0, load_err=0. Release is synchronised externally; first update is on the first rising edge with rst_n=1.
- Per-edge priority (highest first): clr, then load, then en, then hold.
- clr: q←0; held←0; wrap←0; load_err←0.
- load: q←load_val if load_val<MODULUS, else q←MODULUS-1 and load_err←1. Also held←0, wrap←0.
- en with up_dn=1:
  - q<MODULUS-1: q←q+1.
  - q==MODULUS-1, sat=0: q←0, wrap←1.
  - q==MODULUS-1, sat=1: q unchanged, held←1.
- en with up_dn=0:
  - q>0: q←q-1.
  - q==0, sat=0: q←MODULUS-1, wrap←1.
  - q==0, sat=1: q unchanged, held←1.
- held clears on any edge where q changes value, or on clr/load. It stays set while en=0.
- wrap and load_err are 0 on every edge not listed above. They are never high for two consecutive cycles from a single event.
- Arithmetic is modulo MODULUS, never 2**WIDTH, except when MODULUS==2**WIDTH, where the two coincide.
- Changing direction mid-count takes effect on the next enabled edge. There is no dead cycle.
- Toggle formulation: each stage toggles when the next-state bit differs from the current bit. The next state is computed combinationally from the rules above.

## Timing
- Latency: control inputs sampled at rising edge N are reflected in q, wrap, held and load_err after edge N.
- tc is combinational from q, en and up_dn. It is valid in the same cycle and can be cascaded as `en` of a following digit.
- Reset mid-count: asynchronous, takes effect immediately. Any pending wrap or load_err pulse is discarded.
- clr and load in the same cycle: clr wins; load_err is not raised.

## Structure
- Package `counter_pkg`:
  - constants `DIR_UP`=1 and `DIR_DOWN`=0;
  - function `f_next_count(q, up_dn, sat, MODULUS)` returning the next value plus wrap/held flags, shared with the bench model.
- Sub-module `tff_stage`: one T flip-flop with posedge `clk`, async active-low `rst_n`, and a per-bit reset value input. Instantiate WIDTH of them in a generate loop.
- Elaboration checks: error if MODULUS<2, MODULUS>2**WIDTH, or RESET_VAL≥MODULUS.

## Test plan
- Reset/up-wrap (WIDTH=4, MODULUS=10): rst_n low, then en=1, up_dn=1, sat=0 for 12 edges.
  - Expect q=0,1,…,9,0,1.
  - Expect tc=1 only while q=9.
  - Expect wrap=1 for exactly the one cycle after the 9→0 edge.
- Down-wrap: load 2, then en=1, up_dn=0 for 4 edges.
  - Expect q=1,0,9,8.
  - Expect wrap pulse after the 0→9 edge.
- Saturate: sat=1, up from 8 for 4 edges.
  - Expect q=9,9,9,9; held=1 from the second edge onward.
  - Switch to up_dn=0: expect q=8 and held=0.
- Load error: load_val=13 → q=9, load_err pulse for one cycle. Then load_val=5 → q=5, load_err=0.
- Priority/simultaneous: clr=1, load=1, en=1 at q=7 → q=0, no load_err, no wrap. Then load=1, en=1, load_val=3 → q=3.
- Async reset mid-count (RESET_VAL=4): assert rst_n low between edges at q=6.
  - Expect q=4 immediately and wrap/held/load_err=0 before the next clk edge.
  - Expect counting to resume from 4 after release.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// counter_pkg: shared types, direction constants and the next-count rule
// for mod_updown_counter.
//   DIR_UP / DIR_DOWN : values of up_dn
//   cnt_res_t         : next count plus wrap / held flags
//   f_next_count      : one enabled step of a modulo counter (wrap or saturate)
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Fixed evaluation width so the function can serve any counter width up to 31.
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [CNT_W-1:0] nxt;
    logic             wrap;
    logic             held;
  } cnt_res_t;

  function automatic cnt_res_t f_next_count(
    input logic [CNT_W-1:0] q,
    input logic             up_dn,
    input logic             sat,
    input logic [CNT_W-1:0] modulus
  );
    cnt_res_t r;
    r.nxt  = q;
    r.wrap = 1'b0;
    r.held = 1'b0;
    if (up_dn == DIR_UP) begin
      if (q < modulus - 1) begin
        r.nxt = q + 1;
      end else if (!sat) begin
        r.nxt  = '0;
        r.wrap = 1'b1;
      end else begin
        r.held = 1'b1;
      end
    end else begin
      if (q != '0) begin
        r.nxt = q - 1;
      end else if (!sat) begin
        r.nxt  = modulus - 1;
        r.wrap = 1'b1;
      end else begin
        r.held = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_updown_counter_tff_stage.sv
// tff_stage: one toggle flip-flop bit of the counter.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   i_rst_val : value taken while in reset
//   i_t       : toggle request for the next rising edge
//   o_q       : registered bit
module tff_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rst_val,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= i_rst_val;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo-MODULUS up/down counter built from
// toggle stages. Priority per edge: clr, load, en, hold.
//   clk, rst_n         : clock, asynchronous active-low reset
//   en, up_dn, sat     : count enable, direction (1 = up), saturate mode
//   clr, load, load_val: synchronous clear, parallel load and its value
//   q                  : registered count
//   tc                 : combinational terminal count
//   wrap, load_err     : registered one-cycle pulses
//   held               : registered level while parked at a boundary
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             held,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..31");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (64'sd1 <<< WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("mod_updown_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_toggle;
  logic             w_load_ok;
  logic             w_wrap_nxt;
  logic             w_held_nxt;
  logic             w_lerr_nxt;
  cnt_res_t         w_res;
  cnt_res_t         w_res_unused;
  logic             r_wrap;
  logic             r_held;
  logic             r_load_err;

  assign w_res        = f_next_count(CNT_W'(w_q), up_dn, sat, CNT_W'(MODULUS));
  // Upper bits of the shared-width result are always zero for this WIDTH.
  assign w_res_unused = w_res;
  assign w_load_ok    = (CNT_W'(load_val) < CNT_W'(MODULUS));

  always_comb begin
    w_q_nxt    = w_q;
    w_wrap_nxt = 1'b0;
    w_held_nxt = r_held;
    w_lerr_nxt = 1'b0;
    if (clr) begin
      w_q_nxt    = '0;
      w_held_nxt = 1'b0;
    end else if (load) begin
      w_held_nxt = 1'b0;
      if (w_load_ok) begin
        w_q_nxt = load_val;
      end else begin
        w_q_nxt    = MAX_Q;
        w_lerr_nxt = 1'b1;
      end
    end else if (en) begin
      // Every non-saturating enabled step moves q, so held simply follows
      // the saturate flag here.
      w_q_nxt    = w_res.nxt[WIDTH-1:0];
      w_wrap_nxt = w_res.wrap;
      w_held_nxt = w_res.held;
    end
  end

  assign w_toggle = w_q ^ w_q_nxt;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    tff_stage u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rst_val (RST_Q[gi]),
      .i_t       (w_toggle[gi]),
      .o_q       (w_q[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap     <= 1'b0;
      r_held     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_nxt;
      r_held     <= w_held_nxt;
      r_load_err <= w_lerr_nxt;
    end
  end

  assign q        = w_q;
  assign tc       = en & ((up_dn == DIR_UP) ? (w_q == MAX_Q) : (w_q == '0));
  assign wrap     = r_wrap;
  assign held     = r_held;
  assign load_err = r_load_err;

endmodule
